// File: rtl/com_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// com_bus_arbiter_if
// Bundles the per-cache common-bus request/grant lines and the memory snoop
// handshake that meet at com_bus_arbiter.
//
// Parameters
//   N_PROC   number of proc (bus owner) requesters
//   N_SNOOP  number of cache snoop-response requesters
//
// Signals
//   Com_Bus_Req_proc   [N_PROC]   proc bus requests, level
//   Com_Bus_Gnt_proc   [N_PROC]   proc grants, one-hot or zero
//   Com_Bus_Req_snoop  [N_SNOOP]  cache snoop-response requests, level
//   Com_Bus_Gnt_snoop  [N_SNOOP]  cache snoop grants, one-hot or zero
//   Mem_snoop_req                 memory snoop-path request, level
//   Mem_snoop_gnt                 memory snoop grant
//   Bus_busy                      some proc currently owns the bus
//   Owner_id           [OW]       index of the current proc owner, 0 when idle
//   Arb_timeout                   one-cycle pulse on a forced release
//
// Modports
//   master  requester side (caches + memory): drives requests, reads grants
//   slave   arbiter side: reads requests, drives grants and status
// -----------------------------------------------------------------------------
interface com_bus_arbiter_if #(
  parameter int N_PROC  = 8,
  parameter int N_SNOOP = 4
);
  localparam int OW = (N_PROC > 1) ? $clog2(N_PROC) : 1;

  logic [N_PROC-1:0]  Com_Bus_Req_proc;
  logic [N_PROC-1:0]  Com_Bus_Gnt_proc;
  logic [N_SNOOP-1:0] Com_Bus_Req_snoop;
  logic [N_SNOOP-1:0] Com_Bus_Gnt_snoop;
  logic               Mem_snoop_req;
  logic               Mem_snoop_gnt;
  logic               Bus_busy;
  logic [OW-1:0]      Owner_id;
  logic               Arb_timeout;

  modport master (
    output Com_Bus_Req_proc,
    output Com_Bus_Req_snoop,
    output Mem_snoop_req,
    input  Com_Bus_Gnt_proc,
    input  Com_Bus_Gnt_snoop,
    input  Mem_snoop_gnt,
    input  Bus_busy,
    input  Owner_id,
    input  Arb_timeout
  );

  modport slave (
    input  Com_Bus_Req_proc,
    input  Com_Bus_Req_snoop,
    input  Mem_snoop_req,
    output Com_Bus_Gnt_proc,
    output Com_Bus_Gnt_snoop,
    output Mem_snoop_gnt,
    output Bus_busy,
    output Owner_id,
    output Arb_timeout
  );
endinterface

// File: rtl/com_bus_arbiter.sv
// -----------------------------------------------------------------------------
// com_bus_arbiter
// Common-bus arbiter for the MESI multi-cache system.
//   * Proc channel: round-robin choice of one cache controller to own the
//     common bus for a whole BusRd/BusRdX/Invalidate transaction, followed by
//     one turnaround cycle with no owner.
//   * Snoop channel: while a proc owns the bus, grants the snoop-response path
//     to one responding cache (round-robin), or to memory when no cache asks.
//
// Ports
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   com_bus_arbiter_if.slave: request inputs, registered grant/status
//
// Optional feature (macro ARB_TIMEOUT_EN)
//   Defined:   a hold counter forces the owner off the bus after MAX_HOLD
//              grant cycles, pulses Arb_timeout, and masks that requester
//              until its request is seen low.
//   Undefined: no counter or mask, Arb_timeout stays 0, grants are held for
//              as long as the owner requests.
// -----------------------------------------------------------------------------
module com_bus_arbiter #(
  parameter int N_PROC   = 8,
  parameter int N_SNOOP  = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst,
  com_bus_arbiter_if.slave  bus
);

  localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int SW = (N_SNOOP > 1) ? $clog2(N_SNOOP) : 1;

  typedef enum logic [1:0] {P_IDLE, P_GRANT, P_TURN} p_state_t;
  typedef enum logic {S_IDLE, S_GRANT} s_state_t;

  p_state_t           p_state;
  s_state_t           s_state;

  logic [N_PROC-1:0]  gnt_proc;
  logic [PW-1:0]      owner_id;
  logic               bus_busy;
  logic               arb_timeout;
  logic [PW-1:0]      rr_proc_ptr;

  logic [N_SNOOP-1:0] gnt_snoop;
  logic               mem_gnt;
  logic               snoop_is_mem;
  logic [SW-1:0]      snoop_idx;
  logic [SW-1:0]      rr_snoop_ptr;

  logic [N_PROC-1:0]  arb_req;
  logic               timeout_hit;
  logic               owner_req;
  logic               snoop_pending;
  logic               snoop_held;
  logic               normal_release;
  logic               proc_leave;
  logic               snoop_allowed;
  logic [PW-1:0]      proc_pick;
  logic [SW-1:0]      snoop_pick;

  // First set bit at or above ptr, wrapping from the top index back to 0.
  function automatic logic [PW-1:0] pick_proc(input logic [N_PROC-1:0] req,
                                              input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_PROC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_PROC) idx = idx - N_PROC;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [SW-1:0] pick_snoop(input logic [N_SNOOP-1:0] req,
                                               input logic [SW-1:0] ptr);
    logic [SW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_SNOOP; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_SNOOP) idx = idx - N_SNOOP;
      if (!found && req[SW'(idx)]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
    return pick;
  endfunction

  assign owner_req     = bus.Com_Bus_Req_proc[owner_id];
  assign snoop_pending = (|bus.Com_Bus_Req_snoop) | bus.Mem_snoop_req;
  assign snoop_held    = snoop_is_mem ? bus.Mem_snoop_req
                                      : bus.Com_Bus_Req_snoop[snoop_idx];
  assign proc_pick     = pick_proc(arb_req, rr_proc_ptr);
  assign snoop_pick    = pick_snoop(bus.Com_Bus_Req_snoop, rr_snoop_ptr);

  // The owner may only let go once no snoop transfer is running or about to
  // start; a snoop request rising in the same cycle the owner drops wins and
  // the release waits for it.
  assign normal_release = (p_state == P_GRANT) && !owner_req &&
                          (s_state == S_IDLE) && !snoop_pending;
  assign proc_leave     = normal_release | timeout_hit;

  // Snoop grants are never issued on the edge where the proc grant goes away,
  // so a snoop grant always coincides with Bus_busy.
  assign snoop_allowed  = (p_state == P_GRANT) && !proc_leave;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0]     hold_cnt;
  logic [N_PROC-1:0] to_mask;

  // hold_cnt is 0 in the first grant cycle, so MAX_HOLD-1 marks the last
  // allowed one. It saturates so a long snoop transfer cannot wrap it.
  assign timeout_hit = (p_state == P_GRANT) && (s_state == S_IDLE) &&
                       owner_req && (hold_cnt >= HW'(MAX_HOLD - 1));
  assign arb_req     = bus.Com_Bus_Req_proc & ~to_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (p_state != P_GRANT) begin
      hold_cnt <= '0;
    end else if (hold_cnt < HW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // A timed-out requester stays masked until its request is seen low once.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_mask <= '0;
    end else begin
      to_mask <= (to_mask & bus.Com_Bus_Req_proc) |
                 (timeout_hit ? gnt_proc : '0);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign arb_req     = bus.Com_Bus_Req_proc;
`endif

  // Proc FSM: idle arbitration, held grant, one-cycle turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state     <= P_IDLE;
      gnt_proc    <= '0;
      owner_id    <= '0;
      bus_busy    <= 1'b0;
      arb_timeout <= 1'b0;
      rr_proc_ptr <= '0;
    end else begin
      arb_timeout <= 1'b0;
      case (p_state)
        P_IDLE: begin
          if (|arb_req) begin
            p_state  <= P_GRANT;
            gnt_proc <= N_PROC'(1) << proc_pick;
            owner_id <= proc_pick;
            bus_busy <= 1'b1;
          end
        end
        P_GRANT: begin
          if (proc_leave) begin
            p_state     <= P_TURN;
            gnt_proc    <= '0;
            owner_id    <= '0;
            bus_busy    <= 1'b0;
            arb_timeout <= timeout_hit;
            rr_proc_ptr <= (owner_id == PW'(N_PROC - 1)) ? '0 : owner_id + 1'b1;
          end
        end
        P_TURN: begin
          p_state <= P_IDLE;
        end
        default: begin
          p_state <= P_IDLE;
        end
      endcase
    end
  end

  // Snoop FSM: caches beat memory; returning to S_IDLE on release gives the
  // one dead cycle before the next snoop grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state      <= S_IDLE;
      gnt_snoop    <= '0;
      mem_gnt      <= 1'b0;
      snoop_is_mem <= 1'b0;
      snoop_idx    <= '0;
      rr_snoop_ptr <= '0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (snoop_allowed) begin
            if (|bus.Com_Bus_Req_snoop) begin
              s_state      <= S_GRANT;
              gnt_snoop    <= N_SNOOP'(1) << snoop_pick;
              snoop_idx    <= snoop_pick;
              snoop_is_mem <= 1'b0;
            end else if (bus.Mem_snoop_req) begin
              s_state      <= S_GRANT;
              mem_gnt      <= 1'b1;
              snoop_is_mem <= 1'b1;
            end
          end
        end
        S_GRANT: begin
          if (!snoop_held) begin
            s_state   <= S_IDLE;
            gnt_snoop <= '0;
            mem_gnt   <= 1'b0;
            if (!snoop_is_mem) begin
              rr_snoop_ptr <= (snoop_idx == SW'(N_SNOOP - 1)) ? '0 : snoop_idx + 1'b1;
            end
          end
        end
        default: begin
          s_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Com_Bus_Gnt_proc  = gnt_proc;
  assign bus.Com_Bus_Gnt_snoop = gnt_snoop;
  assign bus.Mem_snoop_gnt     = mem_gnt;
  assign bus.Bus_busy          = bus_busy;
  assign bus.Owner_id          = owner_id;
  assign bus.Arb_timeout       = arb_timeout;

endmodule
